decode_queue: RTL and testbench

- Parametrised multi-issue successor to decode_unit; sits between fetch and the issue/register-read stage of the superscalar core.
- Buffers fetched 16-bit instructions in a circular queue and decodes up to ISSUE_W per cycle into a registered output group.
- Closes an issue group early at a branch or at an intra-group RAW hazard.
- Supports stall hold and branch-taken flush.

---
 rtl/decode_queue.sv | 188 ++++++++++++++++++
 tb/tb_decode_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Circular instruction queue feeding an ISSUE_W-wide registered decode group.
// Define DECODE_PERF_EN to add saturating stall/flush/hazard-split counters.
module decode_queue #(
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    parameter int PC_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         stall,
    input  logic                         is_branch_taken,
    input  logic                         in_valid,
    input  logic [$clog2(ISSUE_W+1)-1:0] in_num,
    input  logic [ISSUE_W*16-1:0]        in_instr,
    input  logic [PC_W-1:0]              in_pc,
    output logic                         in_ready,
    output logic [ISSUE_W-1:0]           out_valid,
    output logic [ISSUE_W*4-1:0]         out_opcode,
    output logic [ISSUE_W*3-1:0]         out_rd,
    output logic [ISSUE_W*3-1:0]         out_rs1,
    output logic [ISSUE_W*3-1:0]         out_rs2,
    output logic [ISSUE_W*5-1:0]         out_imm,
    output logic [ISSUE_W-1:0]           out_imm_flag,
    output logic [ISSUE_W-1:0]           out_is_branch,
    output logic [ISSUE_W*PC_W-1:0]      out_branch_target,
`ifdef DECODE_PERF_EN
    output logic [31:0]                  perf_stall_cycles,
    output logic [15:0]                  perf_flush_count,
    output logic [31:0]                  perf_hazard_splits,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [15:0]        instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   push_amt, pop_amt, pop_num;

    logic [3:0]         d_op   [ISSUE_W];
    logic [2:0]         d_rd   [ISSUE_W];
    logic [2:0]         d_rs1  [ISSUE_W];
    logic [2:0]         d_rs2  [ISSUE_W];
    logic [4:0]         d_imm  [ISSUE_W];
    logic [PC_W-1:0]    d_tgt  [ISSUE_W];
    logic [ISSUE_W-1:0] d_immf, cand, is_br, wr_rd, hz, incl;

    logic [ISSUE_W*4-1:0]    nxt_opcode;
    logic [ISSUE_W*3-1:0]    nxt_rd, nxt_rs1, nxt_rs2;
    logic [ISSUE_W*5-1:0]    nxt_imm;
    logic [ISSUE_W-1:0]      nxt_imm_flag, nxt_is_branch;
    logic [ISSUE_W*PC_W-1:0] nxt_target;
`ifdef DECODE_PERF_EN
    logic                    cut;
`endif

    // Handshake: a push of in_num lanes is taken on any edge where in_valid and in_ready are both high
    // and in_num is non-zero; in_ready depends only on the registered count.
    assign in_ready = (count <= CNT_W'(DEPTH - ISSUE_W));
    assign push_amt = (in_valid && in_ready && in_num != '0) ? CNT_W'(in_num) : '0;
    assign pop_amt  = stall ? '0 : pop_num;

    always_ff @(posedge clk) begin
        if (!is_branch_taken) begin
            for (int i = 0; i < ISSUE_W; i++) begin
                if (CNT_W'(i) < push_amt) begin
                    instr_mem[tail + PTR_W'(i)] <= in_instr[16*i +: 16];
                    pc_mem[tail + PTR_W'(i)]    <= in_pc + PC_W'(i);
                end
            end
        end
    end

    // Branch target is computed for every lane, branch or not.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            cand[k]   = CNT_W'(k) < count;
            d_op[k]   = instr_mem[head + PTR_W'(k)][15:12];
            d_rd[k]   = instr_mem[head + PTR_W'(k)][11:9];
            d_rs1[k]  = instr_mem[head + PTR_W'(k)][8:6];
            d_immf[k] = instr_mem[head + PTR_W'(k)][5];
            d_rs2[k]  = d_immf[k] ? 3'd0 : instr_mem[head + PTR_W'(k)][4:2];
            d_imm[k]  = d_immf[k] ? instr_mem[head + PTR_W'(k)][4:0] : 5'd0;
            is_br[k]  = (d_op[k] == 4'hC) || (d_op[k] == 4'hD);
            wr_rd[k]  = (d_op[k] != 4'h0) && !is_br[k];
            d_tgt[k]  = pc_mem[head + PTR_W'(k)] + {{(PC_W-5){d_imm[k][4]}}, d_imm[k]};
        end
    end

    always_comb begin
        hz      = '0;
        incl    = '0;
        pop_num = '0;
`ifdef DECODE_PERF_EN
        cut     = 1'b0;
`endif
        for (int k = 1; k < ISSUE_W; k++) begin
            for (int j = 0; j < k; j++) begin
                if (wr_rd[j] && (d_rd[j] == d_rs1[k] || (!d_immf[k] && d_rd[j] == d_rs2[k])))
                    hz[k] = 1'b1;
            end
        end
        incl[0] = cand[0];
        for (int k = 1; k < ISSUE_W; k++) begin
            incl[k] = incl[k-1] & cand[k] & ~is_br[k-1] & ~hz[k];
`ifdef DECODE_PERF_EN
            if (incl[k-1] && cand[k] && !is_br[k-1] && hz[k])
                cut = 1'b1;
`endif
        end
        for (int k = 0; k < ISSUE_W; k++)
            pop_num = pop_num + CNT_W'(incl[k]);
    end

    always_comb begin
        nxt_opcode    = '0;
        nxt_rd        = '0;
        nxt_rs1       = '0;
        nxt_rs2       = '0;
        nxt_imm       = '0;
        nxt_imm_flag  = '0;
        nxt_is_branch = '0;
        nxt_target    = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (incl[k]) begin
                nxt_opcode[4*k +: 4]       = d_op[k];
                nxt_rd[3*k +: 3]           = d_rd[k];
                nxt_rs1[3*k +: 3]          = d_rs1[k];
                nxt_rs2[3*k +: 3]          = d_rs2[k];
                nxt_imm[5*k +: 5]          = d_imm[k];
                nxt_imm_flag[k]            = d_immf[k];
                nxt_is_branch[k]           = is_br[k];
                nxt_target[PC_W*k +: PC_W] = d_tgt[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || is_branch_taken) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            out_valid         <= '0;
            out_opcode        <= '0;
            out_rd            <= '0;
            out_rs1           <= '0;
            out_rs2           <= '0;
            out_imm           <= '0;
            out_imm_flag      <= '0;
            out_is_branch     <= '0;
            out_branch_target <= '0;
        end else begin
            tail  <= tail + PTR_W'(push_amt);
            head  <= head + PTR_W'(pop_amt);
            count <= count + push_amt - pop_amt;
            if (!stall) begin
                out_valid         <= incl;
                out_opcode        <= nxt_opcode;
                out_rd            <= nxt_rd;
                out_rs1           <= nxt_rs1;
                out_rs2           <= nxt_rs2;
                out_imm           <= nxt_imm;
                out_imm_flag      <= nxt_imm_flag;
                out_is_branch     <= nxt_is_branch;
                out_branch_target <= nxt_target;
            end
        end
    end

`ifdef DECODE_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cycles  <= '0;
            perf_flush_count   <= '0;
            perf_hazard_splits <= '0;
        end else begin
            if (stall && count != '0 && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (is_branch_taken && perf_flush_count != '1)
                perf_flush_count <= perf_flush_count + 16'd1;
            if (!is_branch_taken && !stall && cut && perf_hazard_splits != '1)
                perf_hazard_splits <= perf_hazard_splits + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: reference decode model, expected-entry queue, per-edge group checks.
module tb_decode_queue;
    localparam int ISSUE_W = 2;
    localparam int DEPTH   = 8;
    localparam int PC_W    = 16;
    localparam int EW      = 20 + PC_W;
    localparam int NUM_W   = $clog2(ISSUE_W+1);
    localparam int CNT_W   = $clog2(DEPTH+1);

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    stall = 1'b0;
    logic                    is_branch_taken = 1'b0;
    logic                    in_valid = 1'b0;
    logic [NUM_W-1:0]        in_num = '0;
    logic [ISSUE_W*16-1:0]   in_instr = '0;
    logic [PC_W-1:0]         in_pc = '0;
    logic                    in_ready;
    logic [ISSUE_W-1:0]      out_valid;
    logic [ISSUE_W*4-1:0]    out_opcode;
    logic [ISSUE_W*3-1:0]    out_rd, out_rs1, out_rs2;
    logic [ISSUE_W*5-1:0]    out_imm;
    logic [ISSUE_W-1:0]      out_imm_flag, out_is_branch;
    logic [ISSUE_W*PC_W-1:0] out_branch_target;
    logic [CNT_W-1:0]        count;
`ifdef DECODE_PERF_EN
    logic [31:0]             perf_stall_cycles, perf_hazard_splits;
    logic [15:0]             perf_flush_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [EW-1:0]      exp_q[$];
    logic [EW-1:0]      hold_l [ISSUE_W];
    logic [ISSUE_W-1:0] hold_v = '0;

    decode_queue #(.ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .is_branch_taken(is_branch_taken),
        .in_valid(in_valid), .in_num(in_num), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(in_ready), .out_valid(out_valid), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_imm_flag(out_imm_flag), .out_is_branch(out_is_branch),
        .out_branch_target(out_branch_target),
`ifdef DECODE_PERF_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count),
        .perf_hazard_splits(perf_hazard_splits),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entry layout: {op, rd, rs1, rs2, imm, imm_flag, is_branch, target}
    function automatic logic [EW-1:0] ref_decode(input logic [15:0] ins, input logic [PC_W-1:0] pc);
        logic       immf;
        logic [4:0] imm;
        logic [2:0] rs2;
        logic       br;
        immf = ins[5];
        imm  = immf ? ins[4:0] : 5'd0;
        rs2  = immf ? 3'd0 : ins[4:2];
        br   = (ins[15:12] == 4'hC) || (ins[15:12] == 4'hD);
        return {ins[15:12], ins[11:9], ins[8:6], rs2, imm, immf, br, pc + PC_W'($signed(imm))};
    endfunction

    function automatic logic [3:0] f_op(input logic [EW-1:0] e);  return e[PC_W+19:PC_W+16]; endfunction
    function automatic logic [2:0] f_rd(input logic [EW-1:0] e);  return e[PC_W+15:PC_W+13]; endfunction
    function automatic logic [2:0] f_rs1(input logic [EW-1:0] e); return e[PC_W+12:PC_W+10]; endfunction
    function automatic logic [2:0] f_rs2(input logic [EW-1:0] e); return e[PC_W+9:PC_W+7];   endfunction
    function automatic logic f_immf(input logic [EW-1:0] e);      return e[PC_W+1];          endfunction
    function automatic logic f_br(input logic [EW-1:0] e);        return e[PC_W];            endfunction
    function automatic logic f_wr(input logic [EW-1:0] e);
        return (f_op(e) != 4'h0) && !f_br(e);
    endfunction

    function automatic logic [ISSUE_W-1:0] ref_group();
        logic [ISSUE_W-1:0] m;
        bit stop;
        int n;
        m    = '0;
        stop = 0;
        n    = (exp_q.size() < ISSUE_W) ? exp_q.size() : ISSUE_W;
        for (int k = 0; k < n; k++) begin
            if (k > 0 && f_br(exp_q[k-1])) stop = 1;
            for (int j = 0; j < k; j++) begin
                if (f_wr(exp_q[j]) && (f_rd(exp_q[j]) == f_rs1(exp_q[k]) ||
                    (!f_immf(exp_q[k]) && f_rd(exp_q[j]) == f_rs2(exp_q[k]))))
                    stop = 1;
            end
            if (!stop) m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [EW-1:0] lane_got(input int i);
        return {out_opcode[4*i +: 4], out_rd[3*i +: 3], out_rs1[3*i +: 3], out_rs2[3*i +: 3],
                out_imm[5*i +: 5], out_imm_flag[i], out_is_branch[i], out_branch_target[PC_W*i +: PC_W]};
    endfunction

    task automatic clear_model();
        exp_q.delete();
        hold_v = '0;
        for (int i = 0; i < ISSUE_W; i++) hold_l[i] = '0;
    endtask

    task automatic cycle(input logic v, input logic [NUM_W-1:0] n, input logic [ISSUE_W*16-1:0] ins,
                         input logic [PC_W-1:0] pc, input logic st, input logic fl);
        bit acc;
        logic [ISSUE_W-1:0] ev;
        in_valid = v; in_num = n; in_instr = ins; in_pc = pc; stall = st; is_branch_taken = fl;
        acc = v && (n != 0) && !fl && (exp_q.size() <= DEPTH - ISSUE_W);
        if (fl) begin
            clear_model();
        end else if (!st) begin
            ev = ref_group();
            for (int i = 0; i < ISSUE_W; i++) begin
                if (ev[i]) hold_l[i] = exp_q.pop_front();
                else       hold_l[i] = '0;
            end
            hold_v = ev;
        end
        if (acc) begin
            for (int i = 0; i < ISSUE_W; i++)
                if (i < int'(n)) exp_q.push_back(ref_decode(ins[16*i +: 16], pc + PC_W'(i)));
        end
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(hold_v));
        for (int i = 0; i < ISSUE_W; i++)
            check($sformatf("lane%0d", i), 64'(lane_got(i)), 64'(hold_l[i]));
        check("count", 64'(count), 64'(exp_q.size()));
        check("in_ready", 64'(in_ready), 64'(exp_q.size() <= DEPTH - ISSUE_W));
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        clear_model();
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // independent register decode and a full two-wide group
        cycle(1'b1, 2'd2, {16'h2958, 16'h128C}, 16'h0010, 1'b0, 1'b0);
        idle(1);
        check("t1_grp", 64'(out_valid), 64'h3);
        check("t1_l0_op", 64'(out_opcode[3:0]), 64'h1);
        check("t1_l0_rs2", 64'(out_rs2[2:0]), 64'h3);
        check("t1_l1_rd", 64'(out_rd[5:3]), 64'h4);
        check("t1_l1_rs2", 64'(out_rs2[5:3]), 64'h6);
        check("t1_count", 64'(count), 64'h0);

        // RAW hazard splits the group
        cycle(1'b1, 2'd2, {16'h2854, 16'h128C}, 16'h0020, 1'b0, 1'b0);
        idle(1);
        check("t2_grp1", 64'(out_valid), 64'h1);
        idle(1);
        check("t2_grp2", 64'(out_valid), 64'h1);
        check("t2_op", 64'(out_opcode[3:0]), 64'h2);
        check("t2_rs1", 64'(out_rs1[2:0]), 64'h1);

        // branch closes the group; negative immediate target
        cycle(1'b1, 2'd2, {16'hF4E7, 16'hD07E}, 16'h0010, 1'b0, 1'b0);
        idle(1);
        check("t3_grp1", 64'(out_valid), 64'h1);
        check("t3_isbr", 64'(out_is_branch[0]), 64'h1);
        check("t3_tgt", 64'(out_branch_target[PC_W-1:0]), 64'h000E);
        idle(1);
        check("t3_op", 64'(out_opcode[3:0]), 64'hF);
        check("t3_imm", 64'(out_imm[4:0]), 64'h7);
        check("t3_immf", 64'(out_imm_flag[0]), 64'h1);
        check("t3_rs1", 64'(out_rs1[2:0]), 64'h3);

        // fill under stall, overflow push ignored, then drain two per cycle
        for (int p = 0; p < 5; p++)
            cycle(1'b1, 2'd2, {16'h2958, 16'h128C}, PC_W'(16'h0100 + 2*p), 1'b1, 1'b0);
        check("t4_full_cnt", 64'(count), 64'd8);
        check("t4_full_rdy", 64'(in_ready), 64'd0);
        for (int p = 0; p < 4; p++) begin
            idle(1);
            check("t4_drain_grp", 64'(out_valid), 64'h3);
            check("t4_drain_cnt", 64'(count), 64'(6 - 2*p));
        end

        // flush beats stall and same-cycle push
        for (int p = 0; p < 3; p++)
            cycle(1'b1, 2'd2, {16'h2958, 16'h128C}, PC_W'(16'h0200 + 2*p), 1'b1, 1'b0);
        check("t5_pre_cnt", 64'(count), 64'd6);
        cycle(1'b1, 2'd2, {16'h3A5B, 16'h4C6D}, 16'h0300, 1'b1, 1'b1);
        check("t5_cnt", 64'(count), 64'd0);
        check("t5_valid", 64'(out_valid), 64'd0);
        idle(3);

        // random traffic with wrap-around, stalls and occasional flushes
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, NUM_W'($urandom_range(0, ISSUE_W)),
                  (ISSUE_W*16)'({$urandom(), $urandom()}), PC_W'($urandom()),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0);
        end

        // asynchronous reset mid-stream
        cycle(1'b1, 2'd2, {16'h2958, 16'h128C}, 16'h0400, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, {16'h5A5A, 16'h6B6B}, 16'h0402, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < ISSUE_W; i++)
            check($sformatf("arst_lane%0d", i), 64'(lane_got(i)), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        clear_model();
        in_valid = 1'b0; stall = 1'b0; is_branch_taken = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        cycle(1'b1, 2'd1, {16'h0000, 16'h7123}, 16'hFFFF, 1'b0, 1'b0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
